// File: rtl/evm_multi_candidate_core_pkg.sv
// rtl/evm_multi_candidate_core_pkg.sv - shared types, defaults and helpers for the EVM core
// Contents: evm_state_e FSM encoding, default NUM_CAND/CNT_W, onehot_count(), idx_width()
package evm_pkg;

  localparam int DEFAULT_NUM_CAND = 4;
  localparam int DEFAULT_CNT_W    = 8;
  // Widest candidate vector any build may use; helpers operate on this width.
  localparam int MAX_CAND         = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    WAIT_VOTE,
    WAIT_RELEASE,
    DONE
  } evm_state_e;

  // Number of set bits in a (zero-extended) candidate vector.
  function automatic logic [4:0] onehot_count(input logic [MAX_CAND-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Width of a candidate index: max(1, clog2(n)).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/evm_multi_candidate_core_if.sv
// rtl/evm_multi_candidate_core_if.sv - control/result bundle between the EVM driver and the core
// Signals: switch_on_evm, candidate_ready, vote[NUM_CAND], voting_session_done,
//   display_results[IDX_W], display_results_req, display_winner (driver -> core);
//   candidate_name[IDX_W], results[CNT_W], invalid_results, invalid_votes[CNT_W],
//   voting_in_progress, voting_done (core -> driver)
// Modports: master (driver side), slave (core side)
interface evm_multi_candidate_core_if
  import evm_pkg::*;
#(
  parameter int NUM_CAND = DEFAULT_NUM_CAND,
  parameter int CNT_W    = DEFAULT_CNT_W
);
  localparam int IDX_W = idx_width(NUM_CAND);

  logic                switch_on_evm;
  logic                candidate_ready;
  logic [NUM_CAND-1:0] vote;
  logic                voting_session_done;
  logic [IDX_W-1:0]    display_results;
  logic                display_results_req;
  logic                display_winner;

  logic [IDX_W-1:0]    candidate_name;
  logic [CNT_W-1:0]    results;
  logic                invalid_results;
  logic [CNT_W-1:0]    invalid_votes;
  logic                voting_in_progress;
  logic                voting_done;

  modport master (
    output switch_on_evm, candidate_ready, vote, voting_session_done,
           display_results, display_results_req, display_winner,
    input  candidate_name, results, invalid_results, invalid_votes,
           voting_in_progress, voting_done
  );

  modport slave (
    input  switch_on_evm, candidate_ready, vote, voting_session_done,
           display_results, display_results_req, display_winner,
    output candidate_name, results, invalid_results, invalid_votes,
           voting_in_progress, voting_done
  );

endinterface

// File: rtl/evm_multi_candidate_core_winner_select.sv
// rtl/evm_multi_candidate_core_winner_select.sv - combinational argmax over the tally array
// Ports: tally[NUM_CAND][CNT_W] in; win_idx[IDX_W], win_max[CNT_W], tie out
//   win_idx is the lowest index holding the maximum; tie means the maximum is shared.
module evm_winner_select
  import evm_pkg::*;
#(
  parameter int NUM_CAND = DEFAULT_NUM_CAND,
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int IDX_W    = idx_width(NUM_CAND)
) (
  input  logic [NUM_CAND-1:0][CNT_W-1:0] tally,
  output logic [IDX_W-1:0]               win_idx,
  output logic [CNT_W-1:0]               win_max,
  output logic                           tie
);

  logic [MAX_CAND-1:0] eq_mask;

  // Strict '>' keeps the earliest index when later candidates only match.
  always_comb begin
    win_idx = '0;
    win_max = tally[0];
    for (int i = 1; i < NUM_CAND; i++) begin
      if (tally[i] > win_max) begin
        win_max = tally[i];
        win_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    eq_mask = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      eq_mask[i] = (tally[i] == win_max);
    end
    tie = (onehot_count(eq_mask) > 5'd1);
  end

endmodule

// File: rtl/evm_multi_candidate_core.sv
// rtl/evm_multi_candidate_core.sv - N-candidate voting machine core: ballot FSM, tallies, readback
// Ports: clk, rst (synchronous, active-high), bus (evm_multi_candidate_core_if.slave)
// Parameters: NUM_CAND (2..16), CNT_W (tally/result width), TIMEOUT (idle cycles before abstain)
// Optional feature: define EVM_VOTE_TIMEOUT_EN to return from WAIT_VOTE to WAIT_READY after
//   TIMEOUT cycles without a vote; otherwise WAIT_VOTE waits indefinitely.
module evm_multi_candidate_core
  import evm_pkg::*;
#(
  parameter int NUM_CAND = DEFAULT_NUM_CAND,
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int TIMEOUT  = 255
) (
  input logic                        clk,
  input logic                        rst,
  evm_multi_candidate_core_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_CAND);

  if (NUM_CAND < 2 || NUM_CAND > MAX_CAND || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
    $error("evm_multi_candidate_core: parameter out of range");
  end

  evm_state_e state, state_next;

  logic [NUM_CAND-1:0][CNT_W-1:0] tally;
  logic [4:0]                     vote_bits;
  logic                           clear_counts;
  logic                           cast_valid;
  logic                           cast_invalid;
  logic                           tmo_expired;

  logic [IDX_W-1:0]               win_idx;
  logic [CNT_W-1:0]               win_max;
  logic                           win_tie;
  logic [CNT_W-1:0]               sel_tally;
  logic                           sel_valid;

  assign vote_bits = onehot_count(MAX_CAND'(bus.vote));

  evm_winner_select #(
    .NUM_CAND (NUM_CAND),
    .CNT_W    (CNT_W),
    .IDX_W    (IDX_W)
  ) u_winner_select (
    .tally   (tally),
    .win_idx (win_idx),
    .win_max (win_max),
    .tie     (win_tie)
  );

  // Readback mux; an index with no matching candidate leaves sel_valid low.
  always_comb begin
    sel_tally = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (bus.display_results == IDX_W'(i)) begin
        sel_tally = tally[i];
        sel_valid = 1'b1;
      end
    end
  end

`ifdef EVM_VOTE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero outside WAIT_VOTE, so every entry starts a fresh count.
  // Inside WAIT_VOTE any non-zero vote leaves the state, so each counted cycle had vote==0.
  always_ff @(posedge clk) begin
    if (rst || !bus.switch_on_evm || state != WAIT_VOTE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    clear_counts = 1'b0;
    cast_valid   = 1'b0;
    cast_invalid = 1'b0;
    if (!bus.switch_on_evm) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next   = WAIT_READY;
          clear_counts = 1'b1;
        end
        WAIT_READY: begin
          if (bus.voting_session_done) begin
            state_next = DONE;
          end else if (bus.candidate_ready) begin
            state_next = WAIT_VOTE;
          end
        end
        WAIT_VOTE: begin
          if (vote_bits == 5'd1) begin
            cast_valid = 1'b1;
            state_next = WAIT_RELEASE;
          end else if (vote_bits != 5'd0) begin
            cast_invalid = 1'b1;
            state_next   = WAIT_RELEASE;
          end else if (tmo_expired) begin
            state_next = WAIT_READY;
          end
        end
        WAIT_RELEASE: begin
          // A held button must be released before another ballot can open.
          if (vote_bits == 5'd0) begin
            state_next = WAIT_READY;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      tally                  <= '0;
      bus.invalid_votes      <= '0;
      bus.candidate_name     <= '0;
      bus.results            <= '0;
      bus.invalid_results    <= 1'b0;
      bus.voting_in_progress <= 1'b0;
      bus.voting_done        <= 1'b0;
    end else begin
      state <= state_next;
      if (!bus.switch_on_evm) begin
        // Power-off keeps tallies and the last readback; status flags drop.
        bus.invalid_votes      <= '0;
        bus.invalid_results    <= 1'b0;
        bus.voting_in_progress <= 1'b0;
        bus.voting_done        <= 1'b0;
      end else begin
        // Status flags follow the current state, one cycle behind each transition.
        bus.voting_in_progress <= (state == WAIT_VOTE);
        bus.voting_done        <= (state == DONE);

        if (clear_counts) begin
          tally             <= '0;
          bus.invalid_votes <= '0;
        end

        if (cast_valid) begin
          for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.vote[i] && tally[i] != {CNT_W{1'b1}}) begin
              tally[i] <= tally[i] + CNT_W'(1);
            end
          end
        end

        if (cast_invalid && bus.invalid_votes != {CNT_W{1'b1}}) begin
          bus.invalid_votes <= bus.invalid_votes + CNT_W'(1);
        end

        if (state == DONE) begin
          if (bus.display_winner) begin
            bus.candidate_name  <= win_idx;
            bus.results         <= win_max;
            bus.invalid_results <= win_tie || (win_max == '0);
          end else if (bus.display_results_req) begin
            bus.candidate_name  <= bus.display_results;
            bus.results         <= sel_valid ? sel_tally : '0;
            bus.invalid_results <= !sel_valid;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_evm_multi_candidate_core.sv
// tb/tb_evm_multi_candidate_core.sv - self-checking bench for evm_multi_candidate_core
module tb_evm_multi_candidate_core;
  import evm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  evm_multi_candidate_core_if #(.NUM_CAND(4), .CNT_W(8)) ifa ();
  evm_multi_candidate_core_if #(.NUM_CAND(5), .CNT_W(2)) ifb ();

  evm_multi_candidate_core #(.NUM_CAND(4), .CNT_W(8), .TIMEOUT(10)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  evm_multi_candidate_core #(.NUM_CAND(5), .CNT_W(2), .TIMEOUT(10)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int tests = 0;
  int fails = 0;

  int m_tally [4];
  int m_inv;

  typedef struct {
    logic [3:0] vote;
    int         exp_inv;
  } vec_t;

  vec_t vecs [7];
  int   exp_tab [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic a_power_cycle();
    ifa.switch_on_evm = 1'b0;
    tick();
    ifa.switch_on_evm = 1'b1;
    tick();
  endtask

  task automatic a_ballot(input logic [3:0] v);
    ifa.candidate_ready = 1'b1;
    tick();
    ifa.candidate_ready = 1'b0;
    ifa.vote = v;
    tick();
    ifa.vote = '0;
    tick();
  endtask

  task automatic a_close();
    ifa.voting_session_done = 1'b1;
    tick();
    ifa.voting_session_done = 1'b0;
    tick();
  endtask

  task automatic a_read_idx(input int i);
    ifa.display_results     = 2'(i);
    ifa.display_results_req = 1'b1;
    tick();
    ifa.display_results_req = 1'b0;
  endtask

  task automatic a_read_winner();
    ifa.display_winner = 1'b1;
    tick();
    ifa.display_winner = 1'b0;
  endtask

  task automatic b_ballot(input logic [4:0] v);
    ifb.candidate_ready = 1'b1;
    tick();
    ifb.candidate_ready = 1'b0;
    ifb.vote = v;
    tick();
    ifb.vote = '0;
    tick();
  endtask

  task automatic b_read_idx(input int i);
    ifb.display_results     = 3'(i);
    ifb.display_results_req = 1'b1;
    tick();
    ifb.display_results_req = 1'b0;
  endtask

  task automatic model_reset();
    foreach (m_tally[i]) m_tally[i] = 0;
    m_inv = 0;
  endtask

  task automatic model_ballot(input logic [3:0] v);
    if ($countones(v) == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && m_tally[i] < 255) m_tally[i]++;
      end
    end else if ($countones(v) > 1) begin
      if (m_inv < 255) m_inv++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0100, 0};
    vecs[1] = '{4'b0100, 0};
    vecs[2] = '{4'b0001, 0};
    vecs[3] = '{4'b0100, 0};
    vecs[4] = '{4'b0101, 1};
    vecs[5] = '{4'b1111, 2};
    vecs[6] = '{4'b0010, 2};
    exp_tab = '{1, 1, 3, 0};

    ifa.switch_on_evm = 0; ifa.candidate_ready = 0; ifa.vote = '0;
    ifa.voting_session_done = 0; ifa.display_results = '0;
    ifa.display_results_req = 0; ifa.display_winner = 0;
    ifb.switch_on_evm = 0; ifb.candidate_ready = 0; ifb.vote = '0;
    ifb.voting_session_done = 0; ifb.display_results = '0;
    ifb.display_results_req = 0; ifb.display_winner = 0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_name", ifa.candidate_name, 0);
    check("rst_results", ifa.results, 0);
    check("rst_invalid_results", ifa.invalid_results, 0);
    check("rst_invalid_votes", ifa.invalid_votes, 0);
    check("rst_vip", ifa.voting_in_progress, 0);
    check("rst_done", ifa.voting_done, 0);
    rst = 1'b0;

    // Table-driven session: winner cand 2 with 3 votes, two rejected ballots
    ifa.switch_on_evm = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      a_ballot(vecs[k].vote);
      check($sformatf("tab_inv_votes[%0d]", k), ifa.invalid_votes, vecs[k].exp_inv);
    end
    a_close();
    check("tab_voting_done", ifa.voting_done, 1);
    for (int i = 0; i < 4; i++) begin
      a_read_idx(i);
      check($sformatf("tab_tally%0d", i), ifa.results, exp_tab[i]);
      check($sformatf("tab_name%0d", i), ifa.candidate_name, i);
      check($sformatf("tab_inv%0d", i), ifa.invalid_results, 0);
    end
    a_read_winner();
    check("tab_win_name", ifa.candidate_name, 2);
    check("tab_win_results", ifa.results, 3);
    check("tab_win_invalid", ifa.invalid_results, 0);

    // Multi-press rejected; held vote across two ready pulses counts once
    a_power_cycle();
    check("pwr_inv_votes_cleared", ifa.invalid_votes, 0);
    a_ballot(4'b0101);
    check("multi_inv_votes", ifa.invalid_votes, 1);
    ifa.candidate_ready = 1'b1; tick(); ifa.candidate_ready = 1'b0;
    ifa.vote = 4'b0010; tick();
    ifa.candidate_ready = 1'b1; tick(); ifa.candidate_ready = 1'b0;
    tick();
    ifa.vote = '0; tick();
    tick();
    a_close();
    for (int i = 0; i < 4; i++) begin
      a_read_idx(i);
      check($sformatf("held_tally%0d", i), ifa.results, (i == 1) ? 1 : 0);
    end
    check("held_inv_votes", ifa.invalid_votes, 1);

    // Tie between cands 1 and 3
    a_power_cycle();
    a_ballot(4'b0010); a_ballot(4'b1000); a_ballot(4'b0010); a_ballot(4'b1000);
    a_close();
    a_read_winner();
    check("tie_name", ifa.candidate_name, 1);
    check("tie_results", ifa.results, 2);
    check("tie_invalid", ifa.invalid_results, 1);
    ifa.switch_on_evm = 1'b0;
    tick();
    check("off_results_kept", ifa.results, 2);
    check("off_name_kept", ifa.candidate_name, 1);
    check("off_invalid_cleared", ifa.invalid_results, 0);
    check("off_done_cleared", ifa.voting_done, 0);

    // Zero votes
    ifa.switch_on_evm = 1'b1;
    tick();
    a_close();
    a_read_winner();
    check("zero_name", ifa.candidate_name, 0);
    check("zero_results", ifa.results, 0);
    check("zero_invalid", ifa.invalid_results, 1);

    // Session-done is ignored while a ballot is open
    a_power_cycle();
    ifa.candidate_ready = 1'b1; tick(); ifa.candidate_ready = 1'b0;
    check("vip_lag", ifa.voting_in_progress, 0);
    ifa.voting_session_done = 1'b1; tick();
    check("vip_in_vote", ifa.voting_in_progress, 1);
    check("done_ignored", ifa.voting_done, 0);
    ifa.vote = 4'b1000; tick();
    ifa.vote = '0; tick();
    tick();
    ifa.voting_session_done = 1'b0; tick();
    check("done_after_ready", ifa.voting_done, 1);
    a_read_idx(3);
    check("done_vote_counted", ifa.results, 1);
    check("done_vote_name", ifa.candidate_name, 3);

    // Reset mid-ballot
    a_power_cycle();
    ifa.candidate_ready = 1'b1; tick(); ifa.candidate_ready = 1'b0;
    ifa.vote = 4'b0001; tick();
    rst = 1'b1; tick();
    check("midrst_name", ifa.candidate_name, 0);
    check("midrst_results", ifa.results, 0);
    check("midrst_invalid_results", ifa.invalid_results, 0);
    check("midrst_invalid_votes", ifa.invalid_votes, 0);
    check("midrst_vip", ifa.voting_in_progress, 0);
    check("midrst_done", ifa.voting_done, 0);
    rst = 1'b0;
    ifa.vote = '0;
    tick();

    // Randomized sessions against the reference model
    for (int s = 0; s < 4; s++) begin
      int nb;
      int mx;
      int first;
      int nmax;
      a_power_cycle();
      model_reset();
      nb = $urandom_range(5, 25);
      for (int b = 0; b < nb; b++) begin
        logic [3:0] v;
        v = 4'($urandom_range(1, 15));
        a_ballot(v);
        model_ballot(v);
        check($sformatf("rnd%0d_inv_votes", s), ifa.invalid_votes, m_inv);
      end
      a_close();
      for (int i = 0; i < 4; i++) begin
        a_read_idx(i);
        check($sformatf("rnd%0d_tally%0d", s, i), ifa.results, m_tally[i]);
      end
      mx = 0;
      foreach (m_tally[i]) if (m_tally[i] > mx) mx = m_tally[i];
      first = -1;
      nmax = 0;
      foreach (m_tally[i]) begin
        if (m_tally[i] == mx) begin
          nmax++;
          if (first < 0) first = i;
        end
      end
      a_read_winner();
      check($sformatf("rnd%0d_win_name", s), ifa.candidate_name, first);
      check($sformatf("rnd%0d_win_results", s), ifa.results, mx);
      check($sformatf("rnd%0d_win_invalid", s), ifa.invalid_results,
            (nmax > 1 || mx == 0) ? 1 : 0);
    end

`ifdef EVM_VOTE_TIMEOUT_EN
    // Abstain after TIMEOUT=10 idle cycles in WAIT_VOTE
    a_power_cycle();
    ifa.candidate_ready = 1'b1; tick(); ifa.candidate_ready = 1'b0;
    repeat (10) tick();
    check("tmo_vip_before", ifa.voting_in_progress, 1);
    tick();
    check("tmo_vip_after", ifa.voting_in_progress, 0);
    a_ballot(4'b0100);
    a_close();
    a_read_idx(2);
    check("tmo_next_ballot", ifa.results, 1);
    a_read_idx(0);
    check("tmo_no_tally", ifa.results, 0);
`endif

    // Narrow counters: saturation and out-of-range readback (NUM_CAND=5, CNT_W=2)
    ifb.switch_on_evm = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) b_ballot(5'b00001);
    for (int k = 0; k < 4; k++) b_ballot(5'b00110);
    check("sat_inv_votes", ifb.invalid_votes, 3);
    ifb.voting_session_done = 1'b1; tick(); ifb.voting_session_done = 1'b0; tick();
    b_read_idx(0);
    check("sat_tally0", ifb.results, 3);
    check("sat_tally0_inv", ifb.invalid_results, 0);
    b_read_idx(5);
    check("oor_results", ifb.results, 0);
    check("oor_invalid", ifb.invalid_results, 1);
    ifb.display_winner = 1'b1; tick(); ifb.display_winner = 1'b0;
    check("sat_win_name", ifb.candidate_name, 0);
    check("sat_win_results", ifb.results, 3);
    check("sat_win_invalid", ifb.invalid_results, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
